// File: rtl/mic_decimator.sv
// mic_decimator
// Boxcar decimator for the I2S microphone path. Averages 2**LOG2_RATIO
// consecutive samples per channel and presents each average on a
// valid/ready stream. The input side never stalls. Each channel has one
// pending slot behind the output register. A result that finds its slot
// still full is dropped, and the sticky overrun flag is raised.
//
// Ports:
//   clk_in           system clock
//   rst_in           synchronous active-low reset
//   sample_in        signed PCM sample from the front end
//   sample_ch_in     channel of sample_in (0 = left, 1 = right)
//   sample_valid_in  one-cycle strobe qualifying sample_in/sample_ch_in
//   sample_out       signed decimated sample
//   sample_ch_out    channel of sample_out
//   sample_valid_out output register holds a sample
//   sample_ready_in  downstream accepts the output this cycle
//   overrun_out      sticky: a completed result was dropped
//
// Optional build macro MIC_DECIMATOR_DC_BLOCK_EN inserts a first-order
// DC blocker, which adds one cycle of latency. DC_SHIFT sets its time
// constant.
module mic_decimator #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int LOG2_RATIO   = 2,
  parameter int DC_SHIFT     = 10
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_ch_in,
  input  logic                    sample_valid_in,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_ch_out,
  output logic                    sample_valid_out,
  input  logic                    sample_ready_in,
  output logic                    overrun_out
);

  localparam int RATIO = 1 << LOG2_RATIO;
  // Keep at least one counter bit so the LOG2_RATIO = 0 build elaborates.
  // In that build the counter sits at 0, and every sample is the last one.
  localparam int CNT_W = (LOG2_RATIO > 0) ? LOG2_RATIO : 1;
  localparam int ACC_W = SAMPLE_WIDTH + LOG2_RATIO;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  // Reject parameter values the datapath was not sized for.
  if (LOG2_RATIO < 0 || LOG2_RATIO > 8 || DC_SHIFT < 1) begin : gBadParams
    $error("mic_decimator: LOG2_RATIO must be 0..8 and DC_SHIFT >= 1");
  end

  logic signed [ACC_W-1:0]        acc_q [2];
  logic signed [ACC_W-1:0]        acc_d [2];
  logic        [CNT_W-1:0]        cnt_q [2];
  logic        [CNT_W-1:0]        cnt_d [2];
  logic signed [ACC_W-1:0]        sampleExt;
  logic signed [ACC_W-1:0]        chSum;
  logic                           rawDone;
  logic signed [SAMPLE_WIDTH-1:0] rawResult;

  // Completed-result event as seen by the pending slots.
  logic                    doneEvt;
  logic                    doneCh;
  logic [SAMPLE_WIDTH-1:0] doneData;

  logic [SAMPLE_WIDTH-1:0] pendData_q [2];
  logic [SAMPLE_WIDTH-1:0] pendData_d [2];
  logic [1:0]              pendFull_q, pendFull_d;
  logic [SAMPLE_WIDTH-1:0] outData_q, outData_d;
  logic                    outCh_q, outCh_d;
  logic                    outValid_q, outValid_d;
  logic                    overrun_q, overrun_d;

  logic [1:0]              hit, candValid, taken;
  logic [SAMPLE_WIDTH-1:0] candData [2];
  logic                    outFree, load, sel;

  // Widening a signed value sign-extends it.
  assign sampleExt = ACC_W'($signed(sample_in));

  // Accumulate per channel. The last sample of a window does not go back
  // into the accumulator. It forms the floored average directly, and the
  // channel state returns to zero on the same edge.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    rawDone   = 1'b0;
    chSum     = acc_q[sample_ch_in] + sampleExt;
    rawResult = SAMPLE_WIDTH'(chSum >>> LOG2_RATIO);
    if (sample_valid_in) begin
      if (cnt_q[sample_ch_in] != CNT_LAST) begin
        acc_d[sample_ch_in] = chSum;
        cnt_d[sample_ch_in] = cnt_q[sample_ch_in] + CNT_W'(1);
      end else begin
        acc_d[sample_ch_in] = '0;
        cnt_d[sample_ch_in] = '0;
        rawDone             = 1'b1;
      end
    end
  end

  // Accumulator and counter registers.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      acc_q[0] <= '0;
      acc_q[1] <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef MIC_DECIMATOR_DC_BLOCK_EN
  localparam int DC_W = SAMPLE_WIDTH + DC_SHIFT;
  localparam logic signed [SAMPLE_WIDTH+1:0] Y_MAX =
    $signed({3'b000, {(SAMPLE_WIDTH-1){1'b1}}});
  localparam logic signed [SAMPLE_WIDTH+1:0] Y_MIN =
    $signed({3'b111, {(SAMPLE_WIDTH-1){1'b0}}});

  logic                           stgValid_q, stgCh_q;
  logic signed [SAMPLE_WIDTH-1:0] stgX_q;
  logic signed [DC_W-1:0]         dc_q [2];
  logic signed [DC_W-1:0]         dc_d [2];
  logic signed [DC_W+1:0]         dcErr;
  logic signed [SAMPLE_WIDTH+1:0] yWide;
  logic signed [SAMPLE_WIDTH-1:0] ySat;

  // DC blocker. dc holds the tracked mean with DC_SHIFT fractional bits.
  // The output is the average minus the integer part of the tracked mean,
  // clipped to the sample range. The tracked mean then moves a fraction
  // of the error toward the average.
  always_comb begin
    dc_d  = dc_q;
    dcErr = ((DC_W+2)'(stgX_q) <<< DC_SHIFT) - (DC_W+2)'(dc_q[stgCh_q]);
    yWide = (SAMPLE_WIDTH+2)'(stgX_q)
          - (SAMPLE_WIDTH+2)'(dc_q[stgCh_q] >>> DC_SHIFT);
    if (yWide > Y_MAX) begin
      ySat = SAMPLE_WIDTH'(Y_MAX);
    end else if (yWide < Y_MIN) begin
      ySat = SAMPLE_WIDTH'(Y_MIN);
    end else begin
      ySat = SAMPLE_WIDTH'(yWide);
    end
    if (stgValid_q) begin
      dc_d[stgCh_q] = dc_q[stgCh_q] + DC_W'(dcErr >>> DC_SHIFT);
    end
  end

  // The stage register between the averager and the blocker is the
  // extra cycle of latency this feature adds.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      stgValid_q <= 1'b0;
      stgCh_q    <= 1'b0;
      stgX_q     <= '0;
      dc_q[0]    <= '0;
      dc_q[1]    <= '0;
    end else begin
      stgValid_q <= rawDone;
      stgCh_q    <= sample_ch_in;
      stgX_q     <= rawResult;
      dc_q       <= dc_d;
    end
  end

  assign doneEvt  = stgValid_q;
  assign doneCh   = stgCh_q;
  assign doneData = ySat;
`else
  assign doneEvt  = rawDone;
  assign doneCh   = sample_ch_in;
  assign doneData = rawResult;
`endif

  // Output and pending-slot steering. A result completing this cycle is
  // offered to the output register alongside the pending slots. That
  // bypass gives one cycle of latency when the output is free. A slot
  // that drains on the same edge its channel completes takes the new
  // result, and only a slot that stays full drops the result.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      hit[c]       = doneEvt && (int'(doneCh) == c);
      candValid[c] = pendFull_q[c] || hit[c];
      candData[c]  = pendFull_q[c] ? pendData_q[c] : doneData;
    end
    outFree = !outValid_q || sample_ready_in;
    sel     = !candValid[0];
    load    = outFree && (candValid != 2'b00);

    outValid_d = outValid_q;
    outData_d  = outData_q;
    outCh_d    = outCh_q;
    if (outFree) begin
      outValid_d = load;
    end
    if (load) begin
      outData_d = candData[sel];
      outCh_d   = sel;
    end

    pendFull_d = pendFull_q;
    pendData_d = pendData_q;
    overrun_d  = overrun_q;
    for (int c = 0; c < 2; c++) begin
      taken[c] = load && (int'(sel) == c);
      if (pendFull_q[c]) begin
        if (taken[c]) begin
          pendFull_d[c] = hit[c];
          if (hit[c]) begin
            pendData_d[c] = doneData;
          end
        end else if (hit[c]) begin
          overrun_d = 1'b1;
        end
      end else if (hit[c] && !taken[c]) begin
        pendFull_d[c] = 1'b1;
        pendData_d[c] = doneData;
      end
    end
  end

  // Output register, pending slots and the sticky overrun flag.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pendFull_q    <= '0;
      pendData_q[0] <= '0;
      pendData_q[1] <= '0;
      outData_q     <= '0;
      outCh_q       <= 1'b0;
      outValid_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      pendFull_q <= pendFull_d;
      pendData_q <= pendData_d;
      outData_q  <= outData_d;
      outCh_q    <= outCh_d;
      outValid_q <= outValid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sample_out       = outData_q;
  assign sample_ch_out    = outCh_q;
  assign sample_valid_out = outValid_q;
  assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_mic_decimator.sv
// tb_mic_decimator
// Directed bench for mic_decimator in the default build (LOG2_RATIO = 2,
// no DC blocker). Inputs change 1 ns after a rising edge, and outputs are
// sampled at the same point.
module tb_mic_decimator;

  localparam int SW = 24;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          sample_ch_in = 1'b0;
  logic          sample_valid_in = 1'b0;
  logic [SW-1:0] sample_out;
  logic          sample_ch_out;
  logic          sample_valid_out;
  logic          sample_ready_in = 1'b1;
  logic          overrun_out;

  int cmpCount = 0;
  int errCount = 0;

  mic_decimator #(
    .SAMPLE_WIDTH(SW),
    .LOG2_RATIO(2),
    .DC_SHIFT(10)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .sample_in(sample_in),
    .sample_ch_in(sample_ch_in),
    .sample_valid_in(sample_valid_in),
    .sample_out(sample_out),
    .sample_ch_out(sample_ch_out),
    .sample_valid_out(sample_valid_out),
    .sample_ready_in(sample_ready_in),
    .overrun_out(overrun_out)
  );

  // 100 MHz clock.
  always #5 clk_in = ~clk_in;

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    cmpCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Strobes one sample into the DUT for exactly one clock.
  task automatic applyStimulus(input logic ch, input int val);
    sample_ch_in    = ch;
    sample_in       = SW'(val);
    sample_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    sample_valid_in = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int outData();
    return int'($signed(sample_out));
  endfunction

  initial begin
    $display("[TB] start");

    // Reset state.
    rst_in = 1'b0;
    tick();
    tick();
    checkOutput("rst_valid",   int'(sample_valid_out), 0);
    checkOutput("rst_data",    outData(), 0);
    checkOutput("rst_ch",      int'(sample_ch_out), 0);
    checkOutput("rst_overrun", int'(overrun_out), 0);
    rst_in = 1'b1;
    tick();

    // Basic average: (4+8+12+16)/4 = 10 on the left channel.
    sample_ready_in = 1'b1;
    applyStimulus(1'b0, 4);
    applyStimulus(1'b0, 8);
    applyStimulus(1'b0, 12);
    checkOutput("basic_not_early", int'(sample_valid_out), 0);
    applyStimulus(1'b0, 16);
    checkOutput("basic_valid", int'(sample_valid_out), 1);
    checkOutput("basic_data",  outData(), 10);
    checkOutput("basic_ch",    int'(sample_ch_out), 0);
    tick();
    checkOutput("basic_empty", int'(sample_valid_out), 0);

    // Negative floor: -7 >>> 2 = -2.
    applyStimulus(1'b0, -1);
    applyStimulus(1'b0, -2);
    applyStimulus(1'b0, -2);
    applyStimulus(1'b0, -2);
    checkOutput("neg_valid", int'(sample_valid_out), 1);
    checkOutput("neg_data",  outData(), -2);
    tick();

    // Full-scale positive does not wrap.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h007F_FFFF);
    checkOutput("max_data", outData(), 8388607);
    tick();
    checkOutput("max_empty", int'(sample_valid_out), 0);

    // Interleave with ready low: the left result is presented first.
    sample_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 100);
      applyStimulus(1'b1, -100);
    end
    checkOutput("il_valid", int'(sample_valid_out), 1);
    checkOutput("il_first", outData(), 100);
    checkOutput("il_ch0",   int'(sample_ch_out), 0);
    sample_ready_in = 1'b1;
    tick();
    checkOutput("il_second_valid", int'(sample_valid_out), 1);
    checkOutput("il_second", outData(), -100);
    checkOutput("il_ch1",    int'(sample_ch_out), 1);
    tick();
    checkOutput("il_empty",   int'(sample_valid_out), 0);
    checkOutput("il_overrun", int'(overrun_out), 0);

    // Overrun: three left windows with ready low. The third result drops.
    sample_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1);
    checkOutput("ov_first", outData(), 1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2);
    checkOutput("ov_hold",       outData(), 1);
    checkOutput("ov_no_overrun", int'(overrun_out), 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3);
    checkOutput("ov_overrun",    int'(overrun_out), 1);
    checkOutput("ov_still_first", outData(), 1);
    sample_ready_in = 1'b1;
    tick();
    checkOutput("ov_second_valid", int'(sample_valid_out), 1);
    checkOutput("ov_second", outData(), 2);
    tick();
    checkOutput("ov_empty",  int'(sample_valid_out), 0);
    checkOutput("ov_sticky", int'(overrun_out), 1);

    // Reset mid-accumulation discards the partial sum.
    applyStimulus(1'b0, 1000);
    applyStimulus(1'b0, 1000);
    rst_in = 1'b0;
    tick();
    checkOutput("mr_valid",   int'(sample_valid_out), 0);
    checkOutput("mr_overrun", int'(overrun_out), 0);
    rst_in = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 20);
    checkOutput("mr_not_early", int'(sample_valid_out), 0);
    applyStimulus(1'b0, 20);
    checkOutput("mr_valid_after", int'(sample_valid_out), 1);
    checkOutput("mr_data", outData(), 20);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
